// File: rtl/coax_tx.sv
// -----------------------------------------------------------------------------
// coax_tx -- 3270 coax link serializer and Manchester encoder.
//
// Takes 10-bit words through a one-word holding register and sends them as
// one transmission:
//   line quiesce (6 x '1') -> code violation (3 bit times)
//   -> per word: sync '1', data bits 9..0, parity (even over sync+data+parity)
//   -> ending sequence: end bit '0' followed by a 2-half-cell mini violation.
// If another word is already waiting when a parity cell ends, its sync cell
// follows at once. In that case there is no ending sequence and no new
// quiesce between the two words.
//
// Bit encoding: each cell is two half-cells of CLOCKS_PER_BIT/2 clocks. Bit b
// is driven as ~b in the first half and b in the second half, so a receiver
// that samples in the middle of the second half recovers b.
//
// Ports:
//   clk      in   1  system clock
//   reset_n  in   1  synchronous active-low reset
//   data     in  10  word to transmit, bit 9 first
//   load     in   1  capture strobe, honoured only while ready=1
//   ready    out  1  holding register empty
//   tx       out  1  encoded line data (registered)
//   active   out  1  line-driver enable, high for the whole frame (registered)
//
// Handshake: a transfer happens on a clk edge where load=1 and ready=1. When
// load=1 and ready=0, the input is ignored and the held word is kept. ready
// falls the cycle after a capture. It rises again the cycle after the word
// moves into the shifter, which happens on the first clock of its sync cell.
//
// CLOCKS_PER_BIT must be even and at least 4.
// -----------------------------------------------------------------------------
module coax_tx #(
   parameter int CLOCKS_PER_BIT = 8
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [9:0] data,
   input  logic       load,
   output logic       ready,
   output logic       tx,
   output logic       active
);

   localparam int HALF = CLOCKS_PER_BIT / 2;
   localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_QUIET  = 3'd1;
   localparam logic [2:0] S_CV     = 3'd2;
   localparam logic [2:0] S_SYNC   = 3'd3;
   localparam logic [2:0] S_DATA   = 3'd4;
   localparam logic [2:0] S_PARITY = 3'd5;
   localparam logic [2:0] S_END    = 3'd6;
   localparam logic [2:0] S_MINI   = 3'd7;

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] half_cnt_q, half_cnt_d;   // clock within the current half-cell
   logic [4:0]    half_idx_q, half_idx_d;   // half-cell index within the state
   logic [9:0]    hold_q, hold_d;
   logic          hold_full_q, hold_full_d;
   logic [9:0]    shift_q, shift_d;
   logic          parity_q, parity_d;
   logic          tx_q, tx_d;
   logic          active_q, active_d;

   logic          half_end;
   logic          state_end;

   // Returns the index of the last half-cell of each state.
   function automatic logic [4:0] last_half_idx(input logic [2:0] st);
      logic [4:0] r;
      r = 5'd0;
      case (st)
         S_QUIET:  r = 5'd11;   // 6 cells
         S_CV:     r = 5'd5;    // 3 bit times
         S_DATA:   r = 5'd19;   // 10 cells
         S_SYNC,
         S_PARITY,
         S_END,
         S_MINI:   r = 5'd1;    // one cell
         default:  r = 5'd0;
      endcase
      return r;
   endfunction

   // Line level for a given state and half-cell position.
   // An odd half_idx means the second half of a cell.
   function automatic logic encode(input logic [2:0] st,
                                   input logic [4:0] idx,
                                   input logic       data_bit,
                                   input logic       par_bit);
      logic r;
      r = 1'b0;
      case (st)
         S_IDLE:   r = 1'b0;
         S_QUIET:  r = idx[0];                      // '1' cells
         S_CV:     r = (idx >= 5'd3);               // 3 halves low, 3 high
         S_SYNC:   r = idx[0];                      // '1' cell
         S_DATA:   r = idx[0] ? data_bit : ~data_bit;
         S_PARITY: r = idx[0] ? par_bit : ~par_bit;
         S_END:    r = ~idx[0];                     // '0' cell
         S_MINI:   r = 1'b1;
         default:  r = 1'b0;
      endcase
      return r;
   endfunction

   assign half_end  = (half_cnt_q == HALF_LAST);
   assign state_end = half_end && (half_idx_q == last_half_idx(state_q));

   always_comb begin
      state_d     = state_q;
      half_cnt_d  = half_cnt_q;
      half_idx_d  = half_idx_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      shift_d     = shift_q;
      parity_d    = parity_q;

      // Cell timing runs in every state except IDLE. IDLE keeps the
      // counters at zero so that a frame always starts on a cell boundary.
      if (state_q == S_IDLE) begin
         half_cnt_d = '0;
         half_idx_d = 5'd0;
      end else begin
         half_cnt_d = half_end ? '0 : half_cnt_q + 1'b1;
         if (half_end) begin
            half_idx_d = state_end ? 5'd0 : half_idx_q + 5'd1;
         end
      end

      case (state_q)
         S_IDLE: begin
            // A held word can be waiting here if it was loaded during the
            // ending sequence of the previous frame.
            if (hold_full_q || load) begin
               state_d = S_QUIET;
            end
         end
         S_QUIET: begin
            if (state_end) state_d = S_CV;
         end
         S_CV: begin
            if (state_end) state_d = S_SYNC;
         end
         S_SYNC: begin
            // The word moves to the shifter on the first clock of the sync
            // cell. This frees the holding register for the next word.
            if (hold_full_q && (half_idx_q == 5'd0) && (half_cnt_q == '0)) begin
               shift_d     = hold_q;
               parity_d    = ~(^hold_q);
               hold_full_d = 1'b0;
            end
            if (state_end) state_d = S_DATA;
         end
         S_DATA: begin
            if (half_end && half_idx_q[0]) begin
               shift_d = {shift_q[8:0], 1'b0};
            end
            if (state_end) state_d = S_PARITY;
         end
         S_PARITY: begin
            if (state_end) begin
               state_d = hold_full_q ? S_SYNC : S_END;
            end
         end
         S_END: begin
            if (state_end) state_d = S_MINI;
         end
         S_MINI: begin
            if (state_end) state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Capture only into an empty register. The sync-cell transfer above
      // only fires while the register is full, so it never competes with
      // this capture.
      if (load && !hold_full_q) begin
         hold_d      = data;
         hold_full_d = 1'b1;
      end

      // tx and active are computed from next-state values and then
      // registered. This keeps them aligned with state_q and glitch-free.
      tx_d     = encode(state_d, half_idx_d, shift_d[9], parity_d);
      active_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         half_cnt_q  <= '0;
         half_idx_q  <= 5'd0;
         hold_q      <= 10'd0;
         hold_full_q <= 1'b0;
         shift_q     <= 10'd0;
         parity_q    <= 1'b0;
         tx_q        <= 1'b0;
         active_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         half_cnt_q  <= half_cnt_d;
         half_idx_q  <= half_idx_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         shift_q     <= shift_d;
         parity_q    <= parity_d;
         tx_q        <= tx_d;
         active_q    <= active_d;
      end
   end

   assign ready  = ~hold_full_q;
   assign tx     = tx_q;
   assign active = active_q;

endmodule

// File: tb/tb_coax_tx.sv
// -----------------------------------------------------------------------------
// tb_coax_tx -- directed test of coax_tx at CLOCKS_PER_BIT = 8 and 4.
//
// Every active clock of a frame is recorded. The recording is compared with
// a waveform that the bench builds from the words it sent. Each frame is also
// decoded the way a coax receiver would decode it, by sampling in the middle
// of the second half of each cell.
// -----------------------------------------------------------------------------
module tb_coax_tx;

   logic       clk;
   logic       reset_n;
   logic [9:0] data;
   logic       load8, load4;
   logic       ready8, tx8, active8;
   logic       ready4, tx4, active4;

   coax_tx #(.CLOCKS_PER_BIT(8)) u_dut8 (
      .clk     (clk),
      .reset_n (reset_n),
      .data    (data),
      .load    (load8),
      .ready   (ready8),
      .tx      (tx8),
      .active  (active8)
   );

   coax_tx #(.CLOCKS_PER_BIT(4)) u_dut4 (
      .clk     (clk),
      .reset_n (reset_n),
      .data    (data),
      .load    (load4),
      .ready   (ready4),
      .tx      (tx4),
      .active  (active4)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- bench state ----------------
   int         n_assert;
   int         n_fail;
   logic       sel4;                 // which DUT the tasks drive and record
   logic       cur_tx, cur_act, cur_rdy;
   logic [0:0] rec_q[$];             // recorded tx, one entry per active clock
   logic [0:0] exp_q[$];             // expected tx waveform
   logic [9:0] words_q[$];           // words expected in the current frame
   logic       par_q[$];             // hand-computed parity per word

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and sample 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
      if (sel4) begin
         cur_tx = tx4;  cur_act = active4;  cur_rdy = ready4;
      end else begin
         cur_tx = tx8;  cur_act = active8;  cur_rdy = ready8;
      end
      if (cur_act) rec_q.push_back(cur_tx);
   endtask

   task automatic do_load(input logic [9:0] v);
      data = v;
      if (sel4) load4 = 1'b1;
      else      load8 = 1'b1;
      step();
      load4 = 1'b0;
      load8 = 1'b0;
   endtask

   task automatic wait_ready(input string tag);
      int n;
      n = 0;
      while (!cur_rdy && n < 400) begin
         step();
         n++;
      end
      chk(tag, {31'd0, cur_rdy}, 32'd1);
   endtask

   // Step until active falls. A timeout counts as a failure.
   task automatic run_frame(input string tag);
      int n;
      n = 0;
      while (cur_act && n < 3000) begin
         step();
         n++;
      end
      chk(tag, {31'd0, cur_act}, 32'd0);
   endtask

   task automatic push_half(input logic v, input int cpb);
      for (int i = 0; i < cpb / 2; i++) exp_q.push_back(v);
   endtask

   task automatic push_cell(input logic b, input int cpb);
      push_half(~b, cpb);
      push_half(b, cpb);
   endtask

   task automatic build_exp(input int cpb);
      logic [9:0] w;
      exp_q.delete();
      for (int i = 0; i < 6; i++) push_cell(1'b1, cpb);
      push_half(1'b0, cpb); push_half(1'b0, cpb); push_half(1'b0, cpb);
      push_half(1'b1, cpb); push_half(1'b1, cpb); push_half(1'b1, cpb);
      for (int k = 0; k < words_q.size(); k++) begin
         w = words_q[k];
         push_cell(1'b1, cpb);
         for (int i = 9; i >= 0; i--) push_cell(w[i], cpb);
         push_cell(~(^w), cpb);
      end
      push_cell(1'b0, cpb);
      push_half(1'b1, cpb); push_half(1'b1, cpb);
   endtask

   task automatic check_frame(input string tag, input int cpb, input int exp_len);
      int         mism;
      int         pos;
      logic [9:0] dec;
      build_exp(cpb);
      chk({tag, "_len"}, rec_q.size(), exp_len);
      if (rec_q.size() == exp_q.size()) begin
         mism = 0;
         for (int i = 0; i < exp_q.size(); i++) begin
            if (rec_q[i] !== exp_q[i]) mism++;
         end
         chk({tag, "_wave_mism"}, mism, 0);
         for (int k = 0; k < words_q.size(); k++) begin
            pos = (9 + 12 * k) * cpb + cpb / 2 + cpb / 4;
            chk({tag, "_sync"}, {31'd0, rec_q[pos]}, 32'd1);
            for (int i = 0; i < 10; i++) begin
               pos = (10 + 12 * k + i) * cpb + cpb / 2 + cpb / 4;
               dec[9 - i] = rec_q[pos];
            end
            chk({tag, "_word"}, {22'd0, dec}, {22'd0, words_q[k]});
            pos = (20 + 12 * k) * cpb + cpb / 2 + cpb / 4;
            chk({tag, "_parity"}, {31'd0, rec_q[pos]}, {31'd0, par_q[k]});
         end
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      n_assert = 0;
      n_fail   = 0;
      sel4     = 1'b0;
      reset_n  = 1'b0;
      data     = 10'd0;
      load8    = 1'b0;
      load4    = 1'b0;
      cur_tx   = 1'b0;
      cur_act  = 1'b0;
      cur_rdy  = 1'b0;

      // Reset state of both DUTs.
      repeat (3) step();
      reset_n = 1'b1;
      step();
      chk("rst_ready8",  {31'd0, ready8},  32'd1);
      chk("rst_active8", {31'd0, active8}, 32'd0);
      chk("rst_tx8",     {31'd0, tx8},     32'd0);
      chk("rst_ready4",  {31'd0, ready4},  32'd1);
      chk("rst_active4", {31'd0, active4}, 32'd0);
      chk("rst_tx4",     {31'd0, tx4},     32'd0);

      // Single word 2A5: 23 cells = 184 clocks, parity 0.
      rec_q.delete(); words_q.delete(); par_q.delete();
      words_q.push_back(10'h2A5); par_q.push_back(1'b0);
      do_load(10'h2A5);
      chk("single_ready_low", {31'd0, ready8},  32'd0);
      chk("single_active_hi", {31'd0, active8}, 32'd1);
      run_frame("single_end");
      check_frame("single", 8, 184);
      chk("single_tx_after",    {31'd0, tx8},    32'd0);
      chk("single_ready_after", {31'd0, ready8}, 32'd1);

      // A load while ready=0 is ignored. 0F0 has parity 1.
      rec_q.delete(); words_q.delete(); par_q.delete();
      words_q.push_back(10'h0F0); par_q.push_back(1'b1);
      do_load(10'h0F0);
      do_load(10'h155);
      chk("ignored_ready_low", {31'd0, ready8}, 32'd0);
      run_frame("ignored_end");
      check_frame("ignored", 8, 184);

      // Chained words 000 then 3FF: 21+12+2 = 35 cells = 280 clocks.
      rec_q.delete(); words_q.delete(); par_q.delete();
      words_q.push_back(10'h000); par_q.push_back(1'b1);
      words_q.push_back(10'h3FF); par_q.push_back(1'b1);
      do_load(10'h000);
      wait_ready("chain_ready");
      repeat (20) step();
      do_load(10'h3FF);
      run_frame("chain_end");
      check_frame("chain", 8, 280);

      // The holding register is empty at the last parity clock (clock 168)
      // and the load comes one clock later, during END_BIT. The current
      // frame must still end normally, and the new word then goes out in a
      // fresh frame.
      rec_q.delete(); words_q.delete(); par_q.delete();
      words_q.push_back(10'h1C3); par_q.push_back(1'b0);
      do_load(10'h1C3);
      begin
         int n;
         n = 0;
         while (rec_q.size() < 169 && n < 400) begin
            step();
            n++;
         end
      end
      do_load(10'h2E7);
      run_frame("late_end");
      check_frame("late", 8, 184);
      rec_q.delete(); words_q.delete(); par_q.delete();
      words_q.push_back(10'h2E7); par_q.push_back(1'b0);
      step();
      chk("refill_active", {31'd0, cur_act}, 32'd1);
      chk("refill_ready",  {31'd0, cur_rdy}, 32'd0);
      run_frame("refill_end");
      check_frame("refill", 8, 184);

      // One-cycle reset in the middle of DATA, then a clean frame.
      rec_q.delete();
      do_load(10'h3A5);
      repeat (100) step();
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      chk("midrst_tx",     {31'd0, tx8},     32'd0);
      chk("midrst_active", {31'd0, active8}, 32'd0);
      chk("midrst_ready",  {31'd0, ready8},  32'd1);
      rec_q.delete(); words_q.delete(); par_q.delete();
      words_q.push_back(10'h05A); par_q.push_back(1'b1);
      do_load(10'h05A);
      run_frame("postrst_end");
      check_frame("postrst", 8, 184);

      // Back-to-back words at CLOCKS_PER_BIT=4: 21+24+2 = 47 cells = 188 clocks.
      sel4 = 1'b1;
      cur_rdy = ready4;
      cur_act = active4;
      rec_q.delete(); words_q.delete(); par_q.delete();
      words_q.push_back(10'h155); par_q.push_back(1'b0);
      words_q.push_back(10'h2AB); par_q.push_back(1'b1);
      words_q.push_back(10'h0F1); par_q.push_back(1'b0);
      do_load(10'h155);
      wait_ready("cpb4_ready1");
      do_load(10'h2AB);
      wait_ready("cpb4_ready2");
      do_load(10'h0F1);
      run_frame("cpb4_end");
      check_frame("cpb4", 4, 188);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
